// File: rtl/timer_core.sv
// -----------------------------------------------------------------------------
// timer_core
//   Datapath end of the timer control FSM. It decodes the 3-bit FSM state bus
//   and runs a BCD stopwatch/countdown showing SS.hh (00.00 - 99.99). It owns
//   the 0.01 s tick prescaler, the BCD counter, the function/preset latch and
//   the terminal-count (done) detection.
//
//   Functions (latched in func_q at load time):
//     0: count up   00.00 -> 99.99
//     1: count up   00.00 -> PP.00
//     2: count down 99.99 -> 00.00
//     3: count down PP.00 -> 00.00
//
// Ports
//   clk         in   1   system clock, all logic on posedge
//   reset       in   1   synchronous active-high reset, clears every register
//   state       in   3   FSM state code (IDLE/RUN/PAUSE/ARM/CLEAR/HOLD)
//   func        in   2   function select, sampled only in IDLE/CLEAR
//   preset      in   8   PP seconds as {tens,ones} BCD, sampled only in IDLE/CLEAR
//   bcd         out  16  {sec_tens,sec_ones,hund_tens,hund_ones}, registered
//   running     out  1   registered, high while state is RUN and not done
//   done        out  1   registered level, high while bcd sits at terminal
//   done_pulse  out  1   registered one-cycle strobe on the terminal step
//
// Parameters
//   DIV         clk cycles per 0.01 s step; must be >= 2
// -----------------------------------------------------------------------------
module timer_core #(
    parameter int DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic [1:0]  func,
    input  logic [7:0]  preset,
    output logic [15:0] bcd,
    output logic        running,
    output logic        done,
    output logic        done_pulse
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_RUN   = 3'b001;
    localparam logic [2:0] ST_PAUSE = 3'b010;
    localparam logic [2:0] ST_ARM   = 3'b011;
    localparam logic [2:0] ST_CLEAR = 3'b100;
    localparam logic [2:0] ST_HOLD  = 3'b101;

    typedef enum logic [1:0] {
        M_HOLD = 2'd0,
        M_LOAD = 2'd1,
        M_RUN  = 2'd2
    } mode_e;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [15:0] start_of(input logic [1:0] f, input logic [7:0] p);
        logic [15:0] r;
        case (f)
            2'd2:    r = 16'h9999;
            2'd3:    r = {p, 8'h00};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] terminal_of(input logic [1:0] f, input logic [7:0] p);
        logic [15:0] r;
        case (f)
            2'd0:    r = 16'h9999;
            2'd1:    r = {p, 8'h00};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Ripple increment across the four BCD digits, lowest digit first.
    function automatic logic [15:0] bcd_up(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple decrement across the four BCD digits, lowest digit first.
    function automatic logic [15:0] bcd_down(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [PW-1:0] prescaler;
    logic [1:0]    func_q;
    logic [7:0]    preset_q;

    logic [PW-1:0] prescaler_n;
    logic [1:0]    func_n;
    logic [7:0]    preset_n;
    logic [15:0]   bcd_n;
    logic          done_n;
    logic          done_pulse_n;
    logic          running_n;

    mode_e         mode;
    logic [7:0]    preset_clamped;
    logic [15:0]   step_val;
    logic [15:0]   term_q;

    // Invalid codes fall into the hold group, behaving like PAUSE.
    always_comb begin
        mode = M_HOLD;
        case (state)
            ST_IDLE, ST_CLEAR:         mode = M_LOAD;
            ST_RUN:                    mode = M_RUN;
            ST_PAUSE, ST_ARM, ST_HOLD: mode = M_HOLD;
            default:                   mode = M_HOLD;
        endcase
    end

    assign preset_clamped = {clamp_digit(preset[7:4]), clamp_digit(preset[3:0])};
    assign term_q         = terminal_of(func_q, preset_q);
    assign step_val       = func_q[1] ? bcd_down(bcd) : bcd_up(bcd);

    always_comb begin
        prescaler_n  = prescaler;
        func_n       = func_q;
        preset_n     = preset_q;
        bcd_n        = bcd;
        done_n       = done;
        done_pulse_n = 1'b0;

        case (mode)
            M_LOAD: begin
                func_n      = func;
                preset_n    = preset_clamped;
                bcd_n       = start_of(func, preset_clamped);
                prescaler_n = '0;
                // A preset of 00 in f1/f3 makes start equal terminal: done at load.
                done_n      = (start_of(func, preset_clamped) ==
                               terminal_of(func, preset_clamped));
            end
            M_RUN: begin
                // Once done, the counter freezes; it never steps past terminal.
                if (!done) begin
                    if (prescaler == PRE_MAX) begin
                        prescaler_n = '0;
                        bcd_n       = step_val;
                        if (step_val == term_q) begin
                            done_n       = 1'b1;
                            done_pulse_n = 1'b1;
                        end
                    end else begin
                        prescaler_n = prescaler + 1'b1;
                    end
                end
            end
            default: begin
                // Hold: everything keeps its value, including a partial prescale.
            end
        endcase

        running_n = (mode == M_RUN) && !done_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            func_q     <= 2'd0;
            preset_q   <= 8'h00;
            bcd        <= 16'h0000;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            running    <= 1'b0;
        end else begin
            prescaler  <= prescaler_n;
            func_q     <= func_n;
            preset_q   <= preset_n;
            bcd        <= bcd_n;
            done       <= done_n;
            done_pulse <= done_pulse_n;
            running    <= running_n;
        end
    end

endmodule
